// File: rtl/vga_layer_mux.sv
// vga_layer_mux: two-stage priority compositor with double-buffered config, colour key and blink
module vga_layer_mux #(
  parameter int NUM_LAYERS = 6,
  parameter int COLOR_W = 24,
  parameter logic [COLOR_W-1:0] BG_COLOR = 24'hFFFFFF,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 24'hFF00FF,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LAYERS-1:0]         visible,
  input  logic [NUM_LAYERS*COLOR_W-1:0] rgb_in,
  input  logic                          de_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          cfg_we,
  input  logic [NUM_LAYERS-1:0]         cfg_layer_en,
  input  logic [NUM_LAYERS-1:0]         cfg_key_en,
  input  logic [NUM_LAYERS-1:0]         cfg_blink,
  output logic [COLOR_W-1:0]            rgb_out,
  output logic                          de_out,
  output logic                          hsync_out,
  output logic                          vsync_out
);
  localparam int CW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic                          vs_prev_q, rise, wrap, phase_q, phase_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [NUM_LAYERS-1:0]         pend_en_q, pend_key_q, pend_blink_q;
  logic [NUM_LAYERS-1:0]         pend_en_d, pend_key_d, pend_blink_d;
  logic [NUM_LAYERS-1:0]         act_en_q, act_key_q, act_blink_q;
  logic [NUM_LAYERS-1:0]         act_en_d, act_key_d, act_blink_d;
  logic [NUM_LAYERS-1:0]         qual_d, qual_q;
  logic [NUM_LAYERS*COLOR_W-1:0] rgb_q;
  logic                          de_q, hs_q, vs_q;
  logic [COLOR_W-1:0]            sel, rgb_d;

  // Config shadowing and frame/blink bookkeeping; active copies only move on a vsync rising edge
  always_comb begin
    rise = vsync_in & ~vs_prev_q;
    wrap = cnt_q == CW'(BLINK_FRAMES - 1);
    pend_en_d = cfg_we ? cfg_layer_en : pend_en_q;
    pend_key_d = cfg_we ? cfg_key_en : pend_key_q;
    pend_blink_d = cfg_we ? cfg_blink : pend_blink_q;
    act_en_d = rise ? pend_en_d : act_en_q;
    act_key_d = rise ? pend_key_d : act_key_q;
    act_blink_d = rise ? pend_blink_d : act_blink_q;
    cnt_d = rise ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    phase_d = phase_q ^ (rise & wrap);
  end

  // Per-layer qualification against the active settings
  always_comb begin
    qual_d = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      qual_d[i] = visible[i] & act_en_q[i]
                & ~(act_key_q[i] & (rgb_in[i*COLOR_W +: COLOR_W] == KEY_COLOR))
                & ~(act_blink_q[i] & ~phase_q);
  end

  // Lowest-index qualifying layer wins; blanking forces black
  always_comb begin
    sel = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      sel = qual_q[i] ? rgb_q[i*COLOR_W +: COLOR_W] : sel;
    rgb_d = de_q ? sel : '0;
  end

  // Config, counter and both pipeline stages
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b0;
      cnt_q <= '0;
      phase_q <= 1'b1;
      pend_en_q <= '1;
      pend_key_q <= '0;
      pend_blink_q <= '0;
      act_en_q <= '1;
      act_key_q <= '0;
      act_blink_q <= '0;
      qual_q <= '0;
      rgb_q <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      rgb_out <= '0;
      de_out <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      vs_prev_q <= vsync_in;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      pend_en_q <= pend_en_d;
      pend_key_q <= pend_key_d;
      pend_blink_q <= pend_blink_d;
      act_en_q <= act_en_d;
      act_key_q <= act_key_d;
      act_blink_q <= act_blink_d;
      qual_q <= qual_d;
      rgb_q <= rgb_in;
      de_q <= de_in;
      hs_q <= hsync_in;
      vs_q <= vsync_in;
      rgb_out <= rgb_d;
      de_out <= de_q;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
    end
  end
endmodule

// File: tb/tb_vga_layer_mux.sv
// tb_vga_layer_mux: directed checks of priority, key, double-buffered config, blink and reset
module tb_vga_layer_mux;
  logic          clk = 0, rst = 1;
  logic [5:0]    visible = '0, cfg_layer_en = '1, cfg_key_en = '0, cfg_blink = '0;
  logic [143:0]  rgb_in = '0;
  logic          de_in = 0, hsync_in = 0, vsync_in = 0, cfg_we = 0;
  logic [23:0]   rgb_out;
  logic          de_out, hsync_out, vsync_out;
  int            checks = 0, errors = 0;

  vga_layer_mux #(.NUM_LAYERS(6), .COLOR_W(24), .BG_COLOR(24'hFFFFFF), .KEY_COLOR(24'hFF00FF), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .visible(visible), .rgb_in(rgb_in), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cfg_we(cfg_we),
    .cfg_layer_en(cfg_layer_en), .cfg_key_en(cfg_key_en), .cfg_blink(cfg_blink),
    .rgb_out(rgb_out), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vsync_in = 1;
    tick();
    vsync_in = 0;
    tick();
  endtask

  task automatic cfg(input logic [5:0] en, input logic [5:0] key, input logic [5:0] bl);
    cfg_layer_en = en;
    cfg_key_en = key;
    cfg_blink = bl;
    cfg_we = 1;
    tick();
    cfg_we = 0;
  endtask

  initial begin
    de_in = 1; hsync_in = 1; vsync_in = 1; visible = 6'b000001; rgb_in[0 +: 24] = 24'h123456;
    tick(); tick();
    chk("rst_rgb", rgb_out, 0);
    chk("rst_sync", {de_out, hsync_out, vsync_out}, 0);
    rst = 0; hsync_in = 0; vsync_in = 0; visible = 0;
    tick(); tick();
    chk("bg_rgb", rgb_out, 32'hFFFFFF);
    chk("bg_de", de_out, 1);
    visible = 6'b101100; rgb_in[48 +: 24] = 24'h112233; rgb_in[72 +: 24] = 24'h445566;
    rgb_in[120 +: 24] = 24'h777777; hsync_in = 1;
    tick();
    chk("lat1_rgb", rgb_out, 32'hFFFFFF);
    chk("lat1_hs", hsync_out, 0);
    hsync_in = 0;
    tick();
    chk("prio_rgb", rgb_out, 32'h112233);
    chk("lat2_hs", hsync_out, 1);
    tick();
    chk("hs_fall", hsync_out, 0);
    cfg(6'b111111, 6'b000100, 6'b000000);
    visible = 6'b001100; rgb_in[48 +: 24] = 24'hFF00FF;
    tick(); tick();
    chk("key_pending", rgb_out, 32'hFF00FF);
    vs_pulse(); tick(); tick();
    chk("key_hit", rgb_out, 32'h445566);
    rgb_in[48 +: 24] = 24'h000001;
    tick(); tick();
    chk("key_miss", rgb_out, 32'h000001);
    visible = 6'b000001; rgb_in[0 +: 24] = 24'hABCDEF;
    cfg(6'b111110, 6'b000100, 6'b000000);
    tick(); tick();
    chk("en_pending", rgb_out, 32'hABCDEF);
    tick(); tick();
    chk("en_hold", rgb_out, 32'hABCDEF);
    vs_pulse();
    chk("vs_delay", vsync_out, 1);
    tick();
    chk("vs_fall", vsync_out, 0);
    chk("en_applied", rgb_out, 32'hFFFFFF);
    cfg_layer_en = 6'b111111; cfg_key_en = 0; cfg_blink = 0; cfg_we = 1; vsync_in = 1;
    tick();
    cfg_we = 0; vsync_in = 0;
    tick(); tick();
    chk("coincident", rgb_out, 32'hABCDEF);
    de_in = 0;
    tick(); tick();
    chk("blank_rgb", rgb_out, 0);
    chk("blank_de", de_out, 0);
    de_in = 1;
    tick(); tick();
    chk("unblank", rgb_out, 32'hABCDEF);
    rst = 1;
    tick();
    chk("midrst_rgb", rgb_out, 0);
    chk("midrst_de", de_out, 0);
    rst = 0;
    tick();
    chk("post_rst1", rgb_out, 0);
    tick();
    chk("post_rst2", rgb_out, 32'hABCDEF);
    chk("post_rst2_de", de_out, 1);
    visible = 6'b000011; rgb_in[0 +: 24] = 24'hAAAAAA; rgb_in[24 +: 24] = 24'hBBBBBB;
    cfg(6'b111111, 6'b000000, 6'b000001);
    tick(); tick();
    chk("blink_pending", rgb_out, 32'hAAAAAA);
    vs_pulse(); tick(); tick();
    chk("blink_f1", rgb_out, 32'hAAAAAA);
    vs_pulse(); tick(); tick();
    chk("blink_f2", rgb_out, 32'hBBBBBB);
    vs_pulse(); tick(); tick();
    chk("blink_f3", rgb_out, 32'hBBBBBB);
    vs_pulse(); tick(); tick();
    chk("blink_f4", rgb_out, 32'hAAAAAA);
    vs_pulse(); tick(); tick();
    chk("blink_f5", rgb_out, 32'hAAAAAA);
    vs_pulse(); tick(); tick();
    chk("blink_f6", rgb_out, 32'hBBBBBB);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
